// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 demultiplexer slice.
package demux_pkg;

    localparam logic SEL_Y0 = 1'b0;
    localparam logic SEL_Y1 = 1'b1;

    localparam int unsigned DEMUX_WIDTH = 1;

endpackage : demux_pkg

// File: rtl/demux_out_reg.sv
// One demux output channel: data plus valid register, zeroed when not routed here.
module demux_out_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             route,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    // Unrouted channel is driven to zero every cycle, never held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q       <= route ? d : '0;
            q_valid <= route & d_valid;
        end
    end

endmodule : demux_out_reg

// File: rtl/demux_1to2.sv
// Registered 1-to-2 demultiplexer: steers i to y0 or y1 with one cycle of latency.
module demux_1to2
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [WIDTH-1:0] i,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             y0_valid,
    output logic             y1_valid
);

    logic route0_c;
    logic route1_c;

    // Any sel that is not a clean 1 (including X/Z) routes to channel 0.
    always_comb begin
        route0_c = 1'b1;
        route1_c = 1'b0;
        if (sel == SEL_Y1) begin
            route0_c = 1'b0;
            route1_c = 1'b1;
        end
    end

    demux_out_reg #(.WIDTH(WIDTH)) u_ch0 (
        .clk     (clk),
        .rst     (rst),
        .route   (route0_c),
        .d       (i),
        .d_valid (in_valid),
        .q       (y0),
        .q_valid (y0_valid)
    );

    demux_out_reg #(.WIDTH(WIDTH)) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .route   (route1_c),
        .d       (i),
        .d_valid (in_valid),
        .q       (y1),
        .q_valid (y1_valid)
    );

endmodule : demux_1to2

// File: tb/tb_demux_1to2.sv
// Scoreboard bench for demux_1to2 with a queue-based reference model.
module tb_demux_1to2;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] y0;
        logic [W-1:0] y1;
        logic         v0;
        logic         v1;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic [W-1:0] i;
    logic         in_valid;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic         y0_valid;
    logic         y1_valid;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    demux_1to2 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .i        (i),
        .in_valid (in_valid),
        .y0       (y0),
        .y1       (y1),
        .y0_valid (y0_valid),
        .y1_valid (y1_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the selected channel gets i and in_valid, the other gets zeros.
    function automatic exp_t model(input logic s, input logic [W-1:0] d, input logic v);
        logic [W-1:0] data [2];
        logic         vld  [2];
        exp_t e;
        data = '{default: '0};
        vld  = '{default: 1'b0};
        data[int'(s)] = d;
        vld[int'(s)]  = v;
        e.y0 = data[0];
        e.y1 = data[1];
        e.v0 = vld[0];
        e.v1 = vld[1];
        return e;
    endfunction

    task automatic apply(input logic s, input logic [W-1:0] d, input logic v);
        sel      = s;
        i        = d;
        in_valid = v;
        exp_q.push_back(model(s, d, v));
    endtask

    task automatic step(input logic s, input logic [W-1:0] d, input logic v);
        @(negedge clk);
        apply(s, d, v);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_y0"}, 64'(y0), 64'd0);
        chk({name, "_y1"}, 64'(y1), 64'd0);
        chk({name, "_v0"}, 64'(y0_valid), 64'd0);
        chk({name, "_v1"}, 64'(y1_valid), 64'd0);
    endtask

    // Monitor: after every capture edge outside reset, compare against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("y0", 64'(y0), 64'(e.y0));
            chk("y1", 64'(y1), 64'(e.y1));
            chk("y0_valid", 64'(y0_valid), 64'(e.v0));
            chk("y1_valid", 64'(y1_valid), 64'(e.v1));
            chk("valid_excl", 64'(y0_valid & y1_valid), 64'd0);
        end
    end

    initial begin
        rst      = 1'b1;
        sel      = 1'b1;
        i        = W'(1);
        in_valid = 1'b1;
        #1;
        chk_zero("rst_t0");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;

        // Truth table with single-bit data values.
        step(1'b0, W'(0), 1'b1);
        step(1'b0, W'(1), 1'b1);
        step(1'b1, W'(0), 1'b1);
        step(1'b1, W'(1), 1'b1);

        // Alternating sel, full-width data.
        step(1'b0, 8'hA5, 1'b1);
        step(1'b1, 8'h3C, 1'b1);

        // Data still routed while not valid.
        step(1'b1, 8'hFF, 1'b0);

        // Mid-stream asynchronous reset while y1 holds a valid sample.
        step(1'b1, 8'hFF, 1'b1);
        @(posedge clk);
        #3;
        chk("pre_rst_y1", 64'(y1), 64'hFF);
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_mid_hold");
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, 8'h11, 1'b1);

        // Random regression.
        for (int n = 0; n < 1000; n++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
        end

        // Bounded drain of the scoreboard.
        repeat (3) @(posedge clk);
        #2;
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux_1to2
